rat_intr_ctrl: RTL and testbench

Interrupt controller driving the single `INTV` input of the RAT MCU control unit. It synchronises and edge-detects eight external interrupt sources, latches them as pending, applies a software-programmed mask, and raises `INTV` until the control unit acknowledges entry into the interrupt cycle. It sits on the RAT I/O bus (`PORT_ID`/`OUT_PORT`/`IO_STRB`/`IN_PORT`) beside the other port peripherals and is programmed with `OUT` and read with `IN`.

---
 rtl/rat_intr_ctrl_if.sv | 23 ++
 rtl/rat_intr_ctrl.sv | 115 +++++++++++
 tb/tb_rat_intr_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rat_intr_ctrl_if.sv
// RAT I/O bus plus interrupt handshake between the MCU and the interrupt controller.
// Latency: none, signal bundle only.
// Backpressure: none, because the RAT bus is strobe-based with no ready signal.
interface rat_intr_ctrl_if;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_PORT;
    logic       INT_ACK;
    logic       INTV;

    // MCU / control-unit side
    modport master (
        output PORT_ID, OUT_PORT, IO_STRB, INT_ACK,
        input  IN_PORT, INTV
    );

    // interrupt controller side
    modport slave (
        input  PORT_ID, OUT_PORT, IO_STRB, INT_ACK,
        output IN_PORT, INTV
    );
endinterface

// File: rtl/rat_intr_ctrl.sv
// Eight-source edge-triggered interrupt controller driving the RAT INTV input.
// Latency: a source edge reaches INTV after 4 clocks; register reads are combinational.
// Backpressure: none; a taken request is held until INT_ACK, and the next one waits for a software clear.
module rat_intr_ctrl (
    input  logic             clk,
    input  logic             RESET,
    input  logic [7:0]       IRQ_IN,
    rat_intr_ctrl_if.slave   bus
);
    localparam logic [7:0] MASK_ID = 8'h20;
    localparam logic [7:0] PEND_ID = 8'h21;
    localparam logic [7:0] ACTV_ID = 8'h22;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] s1, s2, s3;
    logic [7:0] irq_edge;
    logic [7:0] pend, mask, req, pend_clr;
    logic [2:0] actv, actv_nxt, req_idx;
    logic       mask_wr, pend_wr;

    assign mask_wr  = bus.IO_STRB && (bus.PORT_ID == MASK_ID);
    assign pend_wr  = bus.IO_STRB && (bus.PORT_ID == PEND_ID);
    assign pend_clr = pend_wr ? bus.OUT_PORT : 8'h00;
    // s3 clears with s2 so a source held high through reset yields exactly one edge
    assign irq_edge = s2 & ~s3;
    assign req      = pend & mask;

    // Two-flop synchroniser plus a delay stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (RESET) begin
            s1 <= 8'h00;
            s2 <= 8'h00;
            s3 <= 8'h00;
        end else begin
            s1 <= IRQ_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Pending and mask registers; a new edge beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (RESET) begin
            pend <= 8'h00;
            mask <= 8'h00;
        end else begin
            pend <= (pend & ~pend_clr) | irq_edge;
            if (mask_wr)
                mask <= bus.OUT_PORT;
        end
    end

    // Lowest set index wins; scanning downward leaves the lowest one in req_idx
    always_comb begin
        req_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i])
                req_idx = 3'(i);
        end
    end

    // FSM state and captured source index
    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= IDLE;
            actv  <= 3'd0;
        end else begin
            state <= state_nxt;
            actv  <= actv_nxt;
        end
    end

    // Next-state: commit to a request, hold it until ack, then wait for the clear
    always_comb begin
        state_nxt = state;
        actv_nxt  = actv;
        case (state)
            IDLE: begin
                if (req != 8'h00) begin
                    actv_nxt  = req_idx;
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                if (bus.INT_ACK)
                    state_nxt = SERVICE;
            end
            SERVICE: begin
                if (!pend[actv])
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // INTV is a decode of the state register, so it comes straight off flops
    assign bus.INTV = (state == ASSERT);

    // Read mux returns zero for foreign port IDs so it can be OR-combined upstream
    always_comb begin
        bus.IN_PORT = 8'h00;
        case (bus.PORT_ID)
            MASK_ID: bus.IN_PORT = mask;
            PEND_ID: bus.IN_PORT = pend;
            ACTV_ID: bus.IN_PORT = {(state == SERVICE), 4'b0000, actv};
            default: bus.IN_PORT = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Testbench for rat_intr_ctrl: directed scenarios plus randomized traffic against a reference model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_rat_intr_ctrl;
    logic       clk = 1'b0;
    logic       RESET;
    logic [7:0] IRQ_IN;
    int         checks = 0;
    int         failures = 0;

    rat_intr_ctrl_if bus_if();

    rat_intr_ctrl dut (
        .clk    (clk),
        .RESET  (RESET),
        .IRQ_IN (IRQ_IN),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model state: pending/mask words, controller phase, serviced index
    logic [7:0] m_pend, m_mask;
    int         m_phase;   // 0 idle, 1 requesting, 2 being serviced
    int         m_actv;
    logic [7:0] irq_hist[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] dat);
        bus_if.PORT_ID  = id;
        bus_if.OUT_PORT = dat;
        bus_if.IO_STRB  = 1'b1;
        cyc();
        bus_if.IO_STRB  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] id, output logic [7:0] dat);
        bus_if.PORT_ID = id;
        #1;
        dat = bus_if.IN_PORT;
    endtask

    task automatic ack();
        bus_if.INT_ACK = 1'b1;
        cyc();
        bus_if.INT_ACK = 1'b0;
    endtask

    task automatic model_reset();
        m_pend = 8'h00;
        m_mask = 8'h00;
        m_phase = 0;
        m_actv = 0;
        irq_hist = '{8'h00, 8'h00, 8'h00};
    endtask

    // Advance the model by one clock using the inputs that were present at that edge
    task automatic model_step(input logic [7:0] irq, input logic strb, input logic [7:0] pid,
                              input logic [7:0] odat, input logic ak);
        logic [7:0] rise;
        logic [7:0] pending_req;
        // a level sampled three clocks ago versus two clocks ago marks a new rise
        rise = irq_hist[1] & ~irq_hist[2];
        irq_hist.push_front(irq);
        void'(irq_hist.pop_back());
        pending_req = m_pend & m_mask;
        if (m_phase == 0) begin
            if (pending_req != 0) begin
                for (int i = 0; i < 8; i++) begin
                    if (pending_req[i]) begin
                        m_actv = i;
                        break;
                    end
                end
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ak) m_phase = 2;
        end else begin
            if (m_pend[m_actv] == 1'b0) m_phase = 0;
        end
        if (strb && pid == 8'h21) m_pend = m_pend & ~odat;
        m_pend = m_pend | rise;
        if (strb && pid == 8'h20) m_mask = odat;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] pid);
        case (pid)
            8'h20: return m_mask;
            8'h21: return m_pend;
            8'h22: return {(m_phase == 2), 4'b0000, 3'(m_actv)};
            default: return 8'h00;
        endcase
    endfunction

    task automatic test_reset();
        logic [7:0] v;
        RESET = 1'b1;
        IRQ_IN = 8'hFF;
        cyc();
        cyc();
        checks++;
        if (bus_if.INTV !== 1'b0) begin
            failures++;
            $display("FAIL reset_intv: got %b want 0", bus_if.INTV);
        end
        rd(8'h20, v);
        checks++;
        if (v !== 8'h00) begin
            failures++;
            $display("FAIL reset_mask: got %h want 00", v);
        end
        RESET = 1'b0;
        cyc();
        cyc();
        rd(8'h21, v);
        checks++;
        if (v !== 8'h00) begin
            failures++;
            $display("FAIL reset_pend_early: got %h want 00", v);
        end
        cyc();
        rd(8'h21, v);
        checks++;
        if (v !== 8'hFF) begin
            failures++;
            $display("FAIL reset_pend_ff: got %h want ff", v);
        end
        cyc();
        checks++;
        if (bus_if.INTV !== 1'b0) begin
            failures++;
            $display("FAIL reset_intv_masked: got %b want 0", bus_if.INTV);
        end
        // source still high: no second edge, so one clear empties PEND
        wr(8'h21, 8'hFF);
        rd(8'h21, v);
        checks++;
        if (v !== 8'h00) begin
            failures++;
            $display("FAIL reset_pend_clear: got %h want 00", v);
        end
        IRQ_IN = 8'h00;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_single();
        logic [7:0] v;
        wr(8'h20, 8'h04);
        IRQ_IN = 8'h04;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 2) IRQ_IN = 8'h00;
            checks++;
            if (bus_if.INTV !== (i == 3)) begin
                failures++;
                $display("FAIL single_latency[%0d]: got %b want %b", i, bus_if.INTV, (i == 3));
            end
        end
        ack();
        checks++;
        if (bus_if.INTV !== 1'b0) begin
            failures++;
            $display("FAIL single_ack_intv: got %b want 0", bus_if.INTV);
        end
        rd(8'h22, v);
        checks++;
        if (v !== 8'h82) begin
            failures++;
            $display("FAIL single_actv: got %h want 82", v);
        end
        wr(8'h21, 8'h04);
        rd(8'h21, v);
        checks++;
        if (v !== 8'h00) begin
            failures++;
            $display("FAIL single_pend_clr: got %h want 00", v);
        end
        cyc();
        rd(8'h22, v);
        checks++;
        if (v !== 8'h02 || bus_if.INTV !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got actv=%h intv=%b want actv=02 intv=0", v, bus_if.INTV);
        end
    endtask

    task automatic test_priority();
        logic [7:0] v;
        wr(8'h20, 8'hFF);
        IRQ_IN = 8'h22;
        for (int i = 0; i < 4; i++) cyc();
        IRQ_IN = 8'h00;
        rd(8'h22, v);
        checks++;
        if (bus_if.INTV !== 1'b1 || v !== 8'h01) begin
            failures++;
            $display("FAIL prio_first: got intv=%b actv=%h want intv=1 actv=01", bus_if.INTV, v);
        end
        ack();
        wr(8'h21, 8'h02);
        cyc();
        checks++;
        if (bus_if.INTV !== 1'b0) begin
            failures++;
            $display("FAIL prio_gap: got %b want 0", bus_if.INTV);
        end
        cyc();
        rd(8'h22, v);
        checks++;
        if (bus_if.INTV !== 1'b1 || v !== 8'h05) begin
            failures++;
            $display("FAIL prio_second: got intv=%b actv=%h want intv=1 actv=05", bus_if.INTV, v);
        end
        ack();
        wr(8'h21, 8'h20);
        cyc();
    endtask

    task automatic test_collision();
        logic [7:0] v;
        wr(8'h20, 8'h00);
        IRQ_IN = 8'h08;
        cyc();
        cyc();
        // the bit-3 edge lands on this write edge
        wr(8'h21, 8'h08);
        rd(8'h21, v);
        checks++;
        if (v !== 8'h08) begin
            failures++;
            $display("FAIL collision_set_wins: got %h want 08", v);
        end
        wr(8'h21, 8'h08);
        rd(8'h21, v);
        checks++;
        if (v !== 8'h00) begin
            failures++;
            $display("FAIL collision_later_clear: got %h want 00", v);
        end
        IRQ_IN = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_committed();
        logic [7:0] v;
        wr(8'h20, 8'h08);
        IRQ_IN = 8'h08;
        for (int i = 0; i < 4; i++) cyc();
        IRQ_IN = 8'h00;
        wr(8'h20, 8'h00);
        cyc();
        cyc();
        checks++;
        if (bus_if.INTV !== 1'b1) begin
            failures++;
            $display("FAIL committed_hold: got %b want 1", bus_if.INTV);
        end
        ack();
        checks++;
        if (bus_if.INTV !== 1'b0) begin
            failures++;
            $display("FAIL committed_ack: got %b want 0", bus_if.INTV);
        end
        wr(8'h21, 8'h08);
        cyc();
        ack();
        cyc();
        rd(8'h22, v);
        checks++;
        if (v !== 8'h03 || bus_if.INTV !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack: got actv=%h intv=%b want actv=03 intv=0", v, bus_if.INTV);
        end
    endtask

    task automatic test_reset_service();
        logic [7:0] v;
        wr(8'h20, 8'h10);
        IRQ_IN = 8'h10;
        for (int i = 0; i < 4; i++) cyc();
        IRQ_IN = 8'h00;
        ack();
        rd(8'h22, v);
        checks++;
        if (v !== 8'h84) begin
            failures++;
            $display("FAIL rst_svc_pre: got %h want 84", v);
        end
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        rd(8'h21, v);
        checks++;
        if (v !== 8'h00 || bus_if.INTV !== 1'b0) begin
            failures++;
            $display("FAIL rst_svc_pend: got pend=%h intv=%b want pend=00 intv=0", v, bus_if.INTV);
        end
        rd(8'h22, v);
        checks++;
        if (v !== 8'h00) begin
            failures++;
            $display("FAIL rst_svc_actv: got %h want 00", v);
        end
        rd(8'h55, v);
        checks++;
        if (v !== 8'h00) begin
            failures++;
            $display("FAIL unused_port: got %h want 00", v);
        end
    endtask

    task automatic test_random();
        logic [7:0] v, exp_v;
        logic [7:0] ids[4];
        int         bad_intv = 0;
        int         bad_read = 0;
        ids = '{8'h20, 8'h21, 8'h22, 8'h55};
        RESET = 1'b1;
        IRQ_IN = 8'h00;
        bus_if.IO_STRB = 1'b0;
        bus_if.INT_ACK = 1'b0;
        cyc();
        cyc();
        RESET = 1'b0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) IRQ_IN[b] = ~IRQ_IN[b];
            bus_if.IO_STRB  = ($urandom_range(0, 3) == 0);
            bus_if.PORT_ID  = ids[$urandom_range(0, 3)];
            bus_if.OUT_PORT = 8'($urandom);
            bus_if.INT_ACK  = (m_phase == 1) ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 9) == 0);
            cyc();
            model_step(IRQ_IN, bus_if.IO_STRB, bus_if.PORT_ID, bus_if.OUT_PORT, bus_if.INT_ACK);
            bus_if.IO_STRB = 1'b0;
            bus_if.INT_ACK = 1'b0;
            checks++;
            if (bus_if.INTV !== (m_phase == 1)) begin
                failures++;
                bad_intv++;
                if (bad_intv <= 5)
                    $display("FAIL rand_intv[%0d]: got %b want %b", n, bus_if.INTV, (m_phase == 1));
            end
            rd(ids[$urandom_range(0, 3)], v);
            exp_v = model_read(bus_if.PORT_ID);
            checks++;
            if (v !== exp_v) begin
                failures++;
                bad_read++;
                if (bad_read <= 5)
                    $display("FAIL rand_read[%0d] id=%h: got %h want %h", n, bus_if.PORT_ID, v, exp_v);
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        IRQ_IN = 8'h00;
        bus_if.PORT_ID = 8'h00;
        bus_if.OUT_PORT = 8'h00;
        bus_if.IO_STRB = 1'b0;
        bus_if.INT_ACK = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_collision();
        test_committed();
        test_reset_service();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
